// File: rtl/logical_reduce_pipe.sv
// logical_reduce_pipe
// Multi-channel logical reduction unit (LNOT / LBOOL / RAND / RXOR per lane)
// behind a valid/ready interface. Results are computed at accept time and
// held in an output register backed by a single skid entry, so the unit
// sustains one transaction per cycle and never drops data under backpressure.
// A saturating counter tracks accepted transactions whose lanes were all true.

module logical_reduce_pipe #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [M*N-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_result,
    output logic             out_all,
    output logic             out_any,
    output logic [CNT_W-1:0] hit_count,
    input  logic             cnt_clear
);

    typedef enum logic [1:0] {
        MODE_LNOT  = 2'b00,
        MODE_LBOOL = 2'b01,
        MODE_RAND  = 2'b10,
        MODE_RXOR  = 2'b11
    } mode_e;

    mode_e          mode;
    logic           accept;
    logic           drain;
    logic           or_free;
    logic [M-1:0]   new_result;
    logic           new_all;
    logic           new_any;
    logic [N-1:0]   lane;

    // Skid entry: holds one transaction accepted while the output register was stalled
    logic           sk_valid;
    logic [M-1:0]   sk_result;
    logic           sk_all;
    logic           sk_any;

    assign mode     = mode_e'(in_mode);
    assign in_ready = ~sk_valid & ~rst;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    // Output register can take new contents when empty or being consumed this cycle
    assign or_free  = ~out_valid | out_ready;

    // Per-lane reduction of the incoming operand under the transaction's mode
    always_comb begin
        new_result = '0;
        lane       = '0;
        for (int unsigned k = 0; k < M; k++) begin
            lane = in_data[k*N +: N];
            case (mode)
                MODE_LNOT:  new_result[k] = ~|lane;
                MODE_LBOOL: new_result[k] = |lane;
                MODE_RAND:  new_result[k] = &lane;
                MODE_RXOR:  new_result[k] = ^lane;
                default:    new_result[k] = 1'b0;
            endcase
        end
        new_all = &new_result;
        new_any = |new_result;
    end

    // Output register and skid entry; skid drains into the output register first
    // so ordering stays FIFO (in_ready is low while skid is occupied)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_all    <= 1'b0;
            out_any    <= 1'b0;
            sk_valid   <= 1'b0;
            sk_result  <= '0;
            sk_all     <= 1'b0;
            sk_any     <= 1'b0;
        end else if (or_free) begin
            if (sk_valid) begin
                out_valid  <= 1'b1;
                out_result <= sk_result;
                out_all    <= sk_all;
                out_any    <= sk_any;
                sk_valid   <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_result <= new_result;
                out_all    <= new_all;
                out_any    <= new_any;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            sk_valid  <= 1'b1;
            sk_result <= new_result;
            sk_all    <= new_all;
            sk_any    <= new_any;
        end
    end

    // Saturating count of all-true accepts; a same-cycle clear discards the hit
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
        end else if (cnt_clear) begin
            hit_count <= '0;
        end else if (accept && new_all && (hit_count != '1)) begin
            hit_count <= hit_count + 1'b1;
        end
    end

    // drain is implied by or_free; kept named for readability of the handshake
    logic unused_drain;
    assign unused_drain = drain;

endmodule

// File: tb/tb_logical_reduce_pipe.sv
// Scoreboard bench for logical_reduce_pipe: a driver presents queued
// stimulus and pushes hand-computed expectations on accept; a monitor
// compares every presented output against the scoreboard head.

module tb_logical_reduce_pipe;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [3:0]  exp;
        logic        clr;
    } stim_t;

    typedef struct {
        logic [3:0] exp;
        int         cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cnt_clear;
    logic [1:0]  in_mode;
    logic [31:0] in_data;
    logic [3:0]  out_result;
    logic        out_all, out_any;
    logic [15:0] hit_count;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, cnt_clear2;
    logic [1:0]  in_mode2;
    logic [31:0] in_data2;
    logic [3:0]  out_result2;
    logic        out_all2, out_any2;
    logic [1:0]  hit_count2;

    stim_t stim[$];
    sb_t   sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_acc = 0;
    int    n_pop = 0;
    bit    chk_lat = 0;

    always #5 clk = ~clk;

    logical_reduce_pipe #(.N(8), .M(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_all(out_all),
        .out_any(out_any), .hit_count(hit_count), .cnt_clear(cnt_clear)
    );

    logical_reduce_pipe #(.N(8), .M(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_mode(in_mode2), .in_data(in_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_result(out_result2), .out_all(out_all2),
        .out_any(out_any2), .hit_count(hit_count2), .cnt_clear(cnt_clear2)
    );

    function automatic logic [3:0] ref_model(logic [1:0] mode, logic [31:0] d);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int pc;
            pc = 0;
            for (int b = 0; b < 8; b++) pc += int'(d[k*8+b]);
            case (mode)
                2'd0: r[k] = (pc == 0);
                2'd1: r[k] = (pc != 0);
                2'd2: r[k] = (pc == 8);
                default: r[k] = (pc % 2 == 1);
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic add(input logic [1:0] m, input logic [31:0] d, input logic [3:0] e, input logic c);
        stim_t s;
        s.mode = m; s.data = d; s.exp = e; s.clr = c;
        stim.push_back(s);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int i;
        i = 0;
        while ((stim.size() != 0 || sb.size() != 0) && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({"idle_", name}, (stim.size() == 0 && sb.size() == 0), 1);
        @(negedge clk);
    endtask

    // Cycle counter for latency measurement
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Driver: presents queue head, records expectation when accepted
    initial begin
        in_valid = 0; in_mode = 0; in_data = 0; cnt_clear = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst && stim.size() > 0) begin
                in_valid  = 1;
                in_mode   = stim[0].mode;
                in_data   = stim[0].data;
                cnt_clear = stim[0].clr;
            end else begin
                in_valid  = 0;
                cnt_clear = 0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb_t e;
                e.exp = stim[0].exp;
                e.cyc = cyc;
                sb.push_back(e);
                void'(stim.pop_front());
                n_acc++;
            end
        end
    end

    // Monitor: every presented output must match the scoreboard head
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output got=%b want=none", out_result);
            end else begin
                logic [3:0] e;
                e = sb[0].exp;
                check("result", {26'd0, out_result, out_all, out_any}, {26'd0, e, &e, |e});
                if (out_ready) begin
                    if (chk_lat) check("latency", cyc - sb[0].cyc, 1);
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
    end

    initial begin
        int start, cnt;
        rst = 1; out_ready = 1;
        in_valid2 = 0; in_mode2 = 0; in_data2 = 0; out_ready2 = 1; cnt_clear2 = 0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Modes, one-cycle latency
        @(posedge clk); #2 chk_lat = 1;
        add(2'b00, 32'h00FF0100, 4'b1001, 0);
        add(2'b01, 32'h00FF0100, 4'b0110, 0);
        add(2'b10, 32'h00FF0100, 4'b0100, 0);
        add(2'b11, 32'h00FF0100, 4'b0010, 0);
        add(2'b00, 32'h00000000, 4'b1111, 0);
        add(2'b10, 32'hFFFFFFFF, 4'b1111, 0);
        add(2'b10, 32'hFEFFFFFF, 4'b0111, 0);
        add(2'b11, 32'h01030700, 4'b1010, 0);
        wait_idle("modes", 50);

        // Counter: clear, three hits, one non-hit
        @(posedge clk); #2;
        add(2'b01, 32'h00000000, 4'b0000, 1);
        add(2'b00, 32'h00000000, 4'b1111, 0);
        add(2'b00, 32'h00000000, 4'b1111, 0);
        add(2'b00, 32'h00000000, 4'b1111, 0);
        add(2'b01, 32'h00000000, 4'b0000, 0);
        wait_idle("cnt", 50);
        check("hit_count_3", hit_count, 3);
        @(posedge clk); #2 add(2'b00, 32'h00000000, 4'b1111, 1);
        wait_idle("cnt_clr", 50);
        check("hit_count_clr", hit_count, 0);
        @(posedge clk); #2 add(2'b10, 32'hFFFFFFFF, 4'b1111, 0);
        wait_idle("cnt_after", 50);
        check("hit_count_1", hit_count, 1);

        // Saturation with CNT_W=2
        @(posedge clk); #2 in_valid2 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sat_count_2", hit_count2, 2);
        repeat (3) @(posedge clk);
        #2 in_valid2 = 0;
        @(negedge clk);
        check("sat_count_5", hit_count2, 3);

        // Backpressure: only OR + SK accepted, then gapless drain
        @(posedge clk); #2 chk_lat = 0; out_ready = 0;
        start = n_acc;
        add(2'b00, 32'h00000000, 4'b1111, 0);
        add(2'b01, 32'h80000001, 4'b1001, 0);
        add(2'b10, 32'hFF00FFFF, 4'b1011, 0);
        add(2'b11, 32'h01030700, 4'b1010, 0);
        add(2'b00, 32'h00100000, 4'b1011, 0);
        repeat (8) @(negedge clk);
        check("bp_accepted", n_acc - start, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk); #2 out_ready = 1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("bp_gapless", cnt, 5);
        wait_idle("bp", 50);

        // Throughput: 100 random transactions, one per cycle
        @(posedge clk); #2 chk_lat = 1;
        start = n_pop;
        for (int i = 0; i < 100; i++) begin
            logic [1:0]  m;
            logic [31:0] d;
            m = 2'($urandom_range(0, 3));
            d = $urandom;
            if (i % 7 == 0) d = 32'h0;
            if (i % 11 == 0) d = 32'hFFFFFFFF;
            add(m, d, ref_model(m, d), 0);
        end
        repeat (2) @(posedge clk);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("tp_per_cycle", cnt, 100);
        wait_idle("tp", 20);
        check("tp_pops", n_pop - start, 100);

        // Mid-flight reset with OR and SK full
        @(posedge clk); #2 chk_lat = 0; out_ready = 0;
        start = n_acc;
        add(2'b01, 32'h11111111, 4'b1111, 0);
        add(2'b11, 32'h01010101, 4'b1111, 0);
        cnt = 0;
        while (n_acc - start < 2 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("mf_accepted", n_acc - start, 2);
        check("mf_in_ready", in_ready, 0);
        @(posedge clk); #2 rst = 1; sb.delete(); stim.delete();
        @(posedge clk); #2 rst = 0; out_ready = 1;
        @(negedge clk);
        check("mf_out_valid", out_valid, 0);
        check("mf_hit_count", hit_count, 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #2 chk_lat = 1;
        add(2'b01, 32'h00000F00, 4'b0010, 0);
        wait_idle("mf", 50);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
